// File: rtl/mario_vertical_mover_if.sv
// Bus between Mario's vertical mover and the rest of the game:
// tile map, horizontal position, buttons and enemy flags in; y and status out.
interface mario_vertical_mover_if;
  logic [11:0][16:0][7:0] background;
  int                     mario_x;
  logic                   jump;
  logic                   lose;
  logic                   stomp;
  int                     mario_y;
  logic                   airborne;
  logic                   dead;

  modport master (
    output background, mario_x, jump, lose, stomp,
    input  mario_y, airborne, dead
  );

  modport slave (
    input  background, mario_x, jump, lose, stomp,
    output mario_y, airborne, dead
  );
endinterface

// File: rtl/mario_vertical_mover.sv
// Mario vertical motion: jump, apex hang, gravity fall, landing, death.
// Define STOMP_BOUNCE_EN to make an enemy stomp launch a rebound rise.
module mario_vertical_mover (
  input logic                    movement_clock,
  input logic                    reset,
  mario_vertical_mover_if.slave  bus
);
  localparam logic [7:0] BLK             = 8'd2;
  localparam logic [7:0] GND             = 8'd3;
  localparam int         CHARACTER_WIDTH = 42;
  localparam int         SCREEN_HEIGHT   = 480;
  localparam int         BLOCK_WIDTH     = 40;
  localparam int         STARTY          = 358;
  localparam logic [6:0] JUMP_HEIGHT     = 7'd120;
  localparam logic [2:0] HANG_LAST       = 3'd7;
`ifdef STOMP_BOUNCE_EN
  localparam logic [6:0] BOUNCE_START    = 7'd60;
`endif

  typedef enum logic [2:0] {
    S_RESET, S_GROUNDED, S_RISE, S_HANG, S_FALL, S_DEAD
  } state_t;

  state_t     state, state_n;
  int         y, y_n;
  logic [6:0] rise_cnt, rise_n;
  logic [2:0] hang_cnt, hang_n;
  logic       jump_q;
  logic       airborne, dead;

  function automatic logic [4:0] clamp_col(input int v);
    if (v < 0) return 5'd0;
    if (v > 16) return 5'd16;
    return 5'(v);
  endfunction

  function automatic logic [3:0] clamp_row(input int v);
    if (v < 0) return 4'd0;
    if (v > 11) return 4'd11;
    return 4'(v);
  endfunction

  function automatic logic solid(input logic [7:0] t);
    return (t == BLK) || (t == GND);
  endfunction

  logic [4:0] col_l, col_r;
  logic [3:0] row_dn, row_up;
  logic       floor_hit, ceil_hit, bottom, jump_edge, in_air;

  assign col_l  = clamp_col(bus.mario_x / BLOCK_WIDTH);
  assign col_r  = clamp_col((bus.mario_x + CHARACTER_WIDTH - 1) / BLOCK_WIDTH);
  assign row_dn = clamp_row((y + CHARACTER_WIDTH) / BLOCK_WIDTH);
  assign row_up = clamp_row((y - 1) / BLOCK_WIDTH);

  assign floor_hit = solid(bus.background[row_dn][col_l])
                   | solid(bus.background[row_dn][col_r]);
  assign ceil_hit  = solid(bus.background[row_up][col_l])
                   | solid(bus.background[row_up][col_r])
                   | (y == 0);
  assign bottom    = (y + CHARACTER_WIDTH) >= SCREEN_HEIGHT;
  assign jump_edge = bus.jump & ~jump_q;
  assign in_air    = (state == S_RISE) || (state == S_HANG)
                   || (state == S_FALL);

  always_comb begin
    state_n = state;
    y_n     = y;
    rise_n  = rise_cnt;
    hang_n  = hang_cnt;
    case (state)
      S_RESET: state_n = S_FALL;
      S_GROUNDED: begin
        if (jump_edge) begin
          state_n = S_RISE;
          rise_n  = 7'd0;
        end else if (!floor_hit) begin
          state_n = S_FALL;
        end
      end
      S_RISE: begin
        if (ceil_hit || rise_cnt == JUMP_HEIGHT) begin
          state_n = S_HANG;
          hang_n  = 3'd0;
        end else begin
          y_n    = y - 1;
          rise_n = rise_cnt + 7'd1;
        end
      end
      S_HANG: begin
        if (hang_cnt == HANG_LAST) state_n = S_FALL;
        else hang_n = hang_cnt + 3'd1;
      end
      S_FALL: begin
        if (floor_hit) state_n = S_GROUNDED;
        else y_n = y + 1;
      end
      S_DEAD:  state_n = S_DEAD;
      default: state_n = S_RESET;
    endcase
`ifdef STOMP_BOUNCE_EN
    // Rebound starts part-way up the jump so it rises only the bounce height.
    if (in_air && bus.stomp) begin
      state_n = S_RISE;
      rise_n  = BOUNCE_START;
      hang_n  = hang_cnt;
      y_n     = y;
    end
`endif
    if (in_air || state == S_GROUNDED) begin
      if (bus.lose || bottom) begin
        state_n = S_DEAD;
        y_n     = y;
        rise_n  = rise_cnt;
        hang_n  = hang_cnt;
      end
    end
  end

  always_ff @(posedge movement_clock) begin
    if (!reset) begin
      state    <= S_RESET;
      y        <= STARTY;
      rise_cnt <= 7'd0;
      hang_cnt <= 3'd0;
      jump_q   <= 1'b0;
      airborne <= 1'b0;
      dead     <= 1'b0;
    end else begin
      state    <= state_n;
      y        <= y_n;
      rise_cnt <= rise_n;
      hang_cnt <= hang_n;
      jump_q   <= bus.jump;
      airborne <= (state_n == S_RISE) || (state_n == S_HANG)
               || (state_n == S_FALL);
      dead     <= (state_n == S_DEAD);
    end
  end

  assign bus.mario_y  = y;
  assign bus.airborne = airborne;
  assign bus.dead     = dead;
endmodule

// File: tb/tb_mario_vertical_mover.sv
// Scoreboard bench for mario_vertical_mover: expected y/airborne/dead
// entries are queued with a due tick and checked when that tick's edge lands.
module tb_mario_vertical_mover;
  logic clk = 1'b0;
  logic reset;
  int   t = 0;
  int   checks = 0;
  int   errors = 0;

  mario_vertical_mover_if bus ();

  mario_vertical_mover dut (
    .movement_clock (clk),
    .reset          (reset),
    .bus            (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) t++;

  typedef struct {
    int    due;
    string tag;
    int    y;
    int    air;
    int    dead;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (tick %0d)", tag, got, want, t);
    end
  endtask

  task automatic expect_at(input int dt, input string tag,
                           input int y, input int air, input int d);
    exp_t e;
    e.due  = t + dt;
    e.tag  = tag;
    e.y    = y;
    e.air  = air;
    e.dead = d;
    sb.push_back(e);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_flat();
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 17; c++)
        bus.background[r][c] = (r >= 10) ? 8'd3 : 8'd1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= t) begin
      e = sb.pop_front();
      chk({e.tag, "_tick"}, t, e.due);
      chk({e.tag, "_y"}, bus.mario_y, e.y);
      chk({e.tag, "_air"}, int'(bus.airborne), e.air);
      chk({e.tag, "_dead"}, int'(bus.dead), e.dead);
    end
  end

  initial begin
    reset       = 1'b0;
    bus.mario_x = 200;
    bus.jump    = 1'b0;
    bus.lose    = 1'b1;
    bus.stomp   = 1'b0;
    set_flat();

    // reset beats a pending lose
    expect_at(1, "rst1", 358, 0, 0);
    expect_at(2, "rst2", 358, 0, 0);
    ticks(2);
    reset    = 1'b1;
    bus.lose = 1'b0;
    expect_at(1, "boot_fall", 358, 1, 0);
    expect_at(2, "boot_land", 358, 0, 0);
    ticks(3);

    // full jump with button held: one jump only
    bus.jump = 1'b1;
    expect_at(1,   "jmp_go",    358, 1, 0);
    expect_at(61,  "jmp_mid",   298, 1, 0);
    expect_at(121, "apex",      238, 1, 0);
    expect_at(122, "hang0",     238, 1, 0);
    expect_at(130, "hang_end",  238, 1, 0);
    expect_at(131, "fall0",     239, 1, 0);
    expect_at(250, "fall_end",  358, 1, 0);
    expect_at(251, "land1",     358, 0, 0);
    expect_at(300, "no_retrig", 358, 0, 0);
    ticks(300);

    // block row 7 overhead caps the rise at 320
    bus.jump = 1'b0;
    ticks(1);
    for (int c = 0; c < 17; c++) bus.background[7][c] = 8'd2;
    bus.jump = 1'b1;
    expect_at(1,  "ceil_go",   358, 1, 0);
    expect_at(39, "ceil_hit",  320, 1, 0);
    expect_at(40, "ceil_hang", 320, 1, 0);
    expect_at(48, "ceil_hend", 320, 1, 0);
    expect_at(49, "ceil_fall", 321, 1, 0);
    expect_at(87, "ceil_land", 358, 0, 0);
    ticks(88);
    set_flat();
    bus.jump = 1'b0;
    ticks(1);

    // stomp pulse while falling through y=300
    bus.jump = 1'b1;
    expect_at(192, "stomp_pre", 300, 1, 0);
`ifdef STOMP_BOUNCE_EN
    expect_at(193, "bounce0",     300, 1, 0);
    expect_at(253, "bounce_top",  240, 1, 0);
    expect_at(262, "bounce_hang", 240, 1, 0);
    expect_at(263, "bounce_fall", 241, 1, 0);
    expect_at(381, "bounce_land", 358, 0, 0);
`else
    expect_at(193, "stomp_ign",  301, 1, 0);
    expect_at(251, "stomp_land", 358, 0, 0);
`endif
    ticks(1);
    bus.jump = 1'b0;
    ticks(191);
    bus.stomp = 1'b1;
    ticks(1);
    bus.stomp = 1'b0;
`ifdef STOMP_BOUNCE_EN
    ticks(190);
`else
    ticks(60);
`endif

    // lose together with stomp mid-rise
    bus.jump = 1'b1;
    expect_at(11, "lose_pre", 348, 1, 0);
    ticks(11);
    bus.lose  = 1'b1;
    bus.stomp = 1'b1;
    expect_at(1, "dead_now",  348, 0, 1);
    expect_at(6, "dead_hold", 348, 0, 1);
    ticks(1);
    bus.stomp = 1'b0;
    bus.jump  = 1'b0;
    ticks(5);
    reset = 1'b0;
    expect_at(1, "rst_dead", 358, 0, 0);
    ticks(1);
    bus.lose = 1'b0;
    reset    = 1'b1;
    expect_at(1, "reboot_fall", 358, 1, 0);
    expect_at(2, "reboot_land", 358, 0, 0);
    ticks(2);

    // ground removed under Mario: fall off the screen
    for (int r = 10; r < 12; r++) begin
      bus.background[r][5] = 8'd1;
      bus.background[r][6] = 8'd1;
    end
    expect_at(1,  "pit_fall",   358, 1, 0);
    expect_at(81, "pit_438",    438, 1, 0);
    expect_at(82, "pit_dead",   438, 0, 1);
    expect_at(90, "pit_frozen", 438, 0, 1);
    ticks(92);

    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
